pc_ir_unit: RTL and testbench

PC_IR_UNIT -- requirements
Module: pc_ir_unit

---
 rtl/pc_ir_unit.sv | 94 +++++++++
 tb/tb_pc_ir_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// Program counter, instruction register, MDR and ALU-output registers for a
// multicycle datapath, with a fetch counter and a sticky misaligned-address flag.
module pc_ir_unit #(
    parameter int unsigned         WIDTH    = 32,
    parameter logic [WIDTH-1:0]    RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcen,
    input  logic [1:0]       pcsrc,
    input  logic             irwrite,
    input  logic             iord,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] memrdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] instret,
    output logic             adrerr
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] aluout_q;
    logic [WIDTH-1:0] instret_q, instret_d;
    logic             adrerr_q, adrerr_d;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] adr_w;

    assign adr_w = iord ? aluout_q : pc_q;

    // Jump target is built from the pre-edge instr, so a simultaneous IR load
    // cannot affect the PC written on the same edge.
    always_comb begin
        next_pc = pc_q;
        unique case (pcsrc)
            2'b00:   next_pc = aluresult;
            2'b01:   next_pc = aluout_q;
            2'b10:   next_pc = {pc_q[31:28], instr_q[25:0], 2'b00};
            default: next_pc = pc_q;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        adrerr_d  = adrerr_q;
        if (pcen) begin
            pc_d = next_pc;
        end
        if (irwrite) begin
            instr_d   = memrdata;
            instret_d = instret_q + WIDTH'(1);
        end
        if (adr_w[1:0] != 2'b00) begin
            adrerr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            data_q    <= '0;
            aluout_q  <= '0;
            instret_q <= '0;
            adrerr_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            data_q    <= memrdata;
            aluout_q  <= aluresult;
            instret_q <= instret_d;
            adrerr_q  <= adrerr_d;
        end
    end

    assign pc      = pc_q;
    assign adr     = adr_w;
    assign instr   = instr_q;
    assign op      = instr_q[31:26];
    assign funct   = instr_q[5:0];
    assign data    = data_q;
    assign aluout  = aluout_q;
    assign instret = instret_q;
    assign adrerr  = adrerr_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios plus randomized
// cycles compared against a behavioural model of the register set.
module tb_pc_ir_unit;

    logic        clk;
    logic        reset;
    logic        pcen;
    logic [1:0]  pcsrc;
    logic        irwrite;
    logic        iord;
    logic [31:0] aluresult;
    logic [31:0] memrdata;
    logic [31:0] pc, adr, instr, data, aluout, instret;
    logic [5:0]  op, funct;
    logic        adrerr;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_data, m_aluout, m_cnt;
    logic        m_err;

    pc_ir_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pcen(pcen), .pcsrc(pcsrc),
        .irwrite(irwrite), .iord(iord), .aluresult(aluresult),
        .memrdata(memrdata), .pc(pc), .adr(adr), .instr(instr),
        .op(op), .funct(funct), .data(data), .aluout(aluout),
        .instret(instret), .adrerr(adrerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_data = 32'h0;
        m_aluout = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
    endtask

    // Advances the model by one edge using current inputs, then waits for the DUT edge.
    task automatic cycle();
        logic [31:0] a, npc;
        a = iord ? m_aluout : m_pc;
        case (pcsrc)
            2'd0: npc = aluresult;
            2'd1: npc = m_aluout;
            2'd2: npc = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
            default: npc = m_pc;
        endcase
        if (a % 4 != 0) m_err = 1'b1;
        if (pcen) m_pc = npc;
        if (irwrite) begin
            m_instr = memrdata;
            m_cnt = m_cnt + 1;
        end
        m_data = memrdata;
        m_aluout = aluresult;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pcen = 0; pcsrc = 2'b11; irwrite = 0; iord = 0;
        aluresult = 0; memrdata = 0;
    endtask

    task automatic test_reset();
        model_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (data !== 32'h0 || aluout !== 32'h0) begin errors++; $display("FAIL reset_data_aluout got %h %h want 0 0", data, aluout); end
        checks++; if (instret !== 32'h0 || adrerr !== 1'b0) begin errors++; $display("FAIL reset_cnt_err got %h %b want 0 0", instret, adrerr); end
        checks++; if (op !== 6'h0 || funct !== 6'h0) begin errors++; $display("FAIL reset_decode got %h %h want 0 0", op, funct); end
        // clock edges while reset is low must not change state
        pcen = 1; pcsrc = 0; irwrite = 1; aluresult = 32'h44; memrdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        checks++; if (pc !== 32'h0 || instret !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL reset_hold got pc=%h cnt=%h instr=%h want 0 0 0", pc, instret, instr); end
        idle_inputs();
        #2 reset = 1;
    endtask

    task automatic test_fetch();
        pcen = 1; pcsrc = 2'b00; irwrite = 1; iord = 0;
        aluresult = 32'h4; memrdata = 32'h2002_0005;
        #1;
        checks++; if (adr !== m_pc) begin errors++; $display("FAIL fetch_adr got %h want %h", adr, m_pc); end
        cycle();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL fetch_pc got %h want 4", pc); end
        checks++; if (instr !== 32'h2002_0005) begin errors++; $display("FAIL fetch_instr got %h want 20020005", instr); end
        checks++; if (op !== 6'h08 || funct !== 6'h05) begin errors++; $display("FAIL fetch_decode got %h %h want 08 05", op, funct); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL fetch_instret got %0d want 1", instret); end
        checks++; if (data !== 32'h2002_0005 || aluout !== 32'h4) begin errors++; $display("FAIL fetch_mdr_aluout got %h %h want 20020005 4", data, aluout); end
    endtask

    task automatic test_branch();
        idle_inputs(); aluresult = 32'h10;
        cycle();
        pcen = 1; pcsrc = 2'b01; aluresult = 32'h0000_0BAD;
        cycle();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL branch_pc got %h want 10", pc); end
        pcen = 0; pcsrc = 2'b00; aluresult = 32'h0000_0200;
        cycle();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL branch_hold got %h want 10", pc); end
    endtask

    task automatic test_jump();
        pcen = 1; pcsrc = 2'b00; irwrite = 1; iord = 0;
        aluresult = 32'h4000_0008; memrdata = 32'h0800_0011;
        cycle();
        pcsrc = 2'b10; memrdata = 32'h0; aluresult = 32'h0;
        cycle();
        checks++; if (pc !== 32'h4000_0044) begin errors++; $display("FAIL jump_pc got %h want 40000044", pc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL jump_instr got %h want 0", instr); end
    endtask

    task automatic test_load_adr();
        idle_inputs(); iord = 1; aluresult = 32'h54;
        cycle();
        checks++; if (adr !== 32'h54 || adrerr !== 1'b0) begin errors++; $display("FAIL ld_aligned got %h %b want 54 0", adr, adrerr); end
        aluresult = 32'h55;
        cycle();
        checks++; if (adr !== 32'h55 || adrerr !== 1'b0) begin errors++; $display("FAIL ld_misaligned got %h %b want 55 0", adr, adrerr); end
        aluresult = 32'h0;
        cycle();
        checks++; if (adrerr !== 1'b1) begin errors++; $display("FAIL ld_err_set got %b want 1", adrerr); end
        iord = 0;
        cycle(); cycle();
        checks++; if (adrerr !== 1'b1) begin errors++; $display("FAIL ld_err_sticky got %b want 1", adrerr); end
    endtask

    task automatic test_wrap();
        idle_inputs();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h want ffffffff", instret); end
        irwrite = 1; memrdata = 32'h1234_5678;
        cycle();
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL wrap_instret got %h want 0", instret); end
        irwrite = 0;
    endtask

    task automatic test_async_reset();
        idle_inputs(); pcen = 1; pcsrc = 2'b00; aluresult = 32'h20; irwrite = 1; memrdata = 32'hABCD_0001;
        cycle();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL ar_setup got %h want 20", pc); end
        #2 reset = 0;
        #1;
        model_reset();
        checks++; if (pc !== 32'h0 || instret !== 32'h0) begin errors++; $display("FAIL ar_immediate got pc=%h cnt=%h want 0 0", pc, instret); end
        checks++; if (instr !== 32'h0 || adrerr !== 1'b0 || op !== 6'h0 || funct !== 6'h0) begin errors++; $display("FAIL ar_clear got instr=%h err=%b want 0 0", instr, adrerr); end
        @(posedge clk); #2 reset = 1;
        pcen = 1; pcsrc = 2'b00; aluresult = 32'h8; irwrite = 1; memrdata = 32'h0000_0024;
        cycle();
        checks++; if (pc !== 32'h8 || instr !== 32'h24 || instret !== 32'd1) begin errors++; $display("FAIL ar_resume got pc=%h instr=%h cnt=%h want 8 24 1", pc, instr, instret); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            pcen = 1'($urandom); pcsrc = 2'($urandom); irwrite = 1'($urandom);
            iord = 1'($urandom); memrdata = $urandom;
            aluresult = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            #1;
            checks++; if (adr !== (iord ? m_aluout : m_pc)) begin errors++; $display("FAIL rnd_adr[%0d] got %h want %h", i, adr, iord ? m_aluout : m_pc); end
            cycle();
            checks++;
            if (pc !== m_pc || instr !== m_instr || data !== m_data || aluout !== m_aluout ||
                instret !== m_cnt || adrerr !== m_err || op !== m_instr[31:26] || funct !== m_instr[5:0]) begin
                errors++;
                $display("FAIL rnd_state[%0d] got pc=%h ir=%h d=%h ao=%h n=%h e=%b want pc=%h ir=%h d=%h ao=%h n=%h e=%b",
                         i, pc, instr, data, aluout, instret, adrerr, m_pc, m_instr, m_data, m_aluout, m_cnt, m_err);
            end
        end
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        #12;
        test_reset();
        @(posedge clk); #1;
        test_fetch();
        test_branch();
        test_jump();
        test_load_adr();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
